jk_bank_ctrl: RTL and testbench
===============================

Name: jk_bank_ctrl

Overview:
- Command-driven sequencer for a bank of WIDTH JK flip-flops.
- Accepts one command at a time over a valid/ready handshake. Translates it into per-bit J/K drive: hold, set, reset, toggle, or a multi-cycle synchronous up/down count of programmable length.
- Owns the flop bank and exposes Q/QB, so datapath blocks no longer wire individual JK cells by hand.

Parameters:
- WIDTH, 4, number of JK flops in the bank (1..16).
- LEN_W, 8, width of the count-length field.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  block can accept a command.
- CMD_OP  input  3  0 HOLD, 1 SET, 2 RESET, 3 TOGGLE, 4 COUNT_UP, 5 COUNT_DOWN, 6-7 illegal.
- CMD_MASK  input  WIDTH  bit select for ops 1-3; ignored for 0, 4, 5.
- CMD_LEN  input  LEN_W  count steps for ops 4-5; ignored otherwise.
- J_OUT  output  WIDTH  J drive applied to the bank this cycle (debug/observe).
- K_OUT  output  WIDTH  K drive applied to the bank this cycle.
- Q  output  WIDTH  flop bank state.
- QB  output  WIDTH  ~Q, combinational.
- BUSY  output  1  command in progress.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  one-cycle pulse, coincident with DONE, for an illegal op.

Behaviour:
- Reset (RST_N=0 at a rising edge) gives Q=0, QB=all ones, state IDLE, CMD_READY=1, BUSY=0, DONE=0, ERR=0, J_OUT=K_OUT=0, all latched command fields cleared.
- Reset overrides everything, including a command in flight. An aborted command produces no DONE.
- Each bank bit follows JK rules every edge:
  - J=0, K=0: hold.
  - J=1, K=0: Q=1.
  - J=0, K=1: Q=0.
  - J=1, K=1: toggle.
- J_OUT/K_OUT are 0 whenever the state is not APPLY or COUNT.
- States:
  - IDLE: CMD_READY=1, BUSY=0.
  - APPLY: BUSY=1, CMD_READY=0.
  - COUNT: BUSY=1, CMD_READY=0.
  - FIN: BUSY=1, CMD_READY=0, DONE=1.
- Handshake: a command is accepted at edge E0 only when CMD_VALID=1 and the state is IDLE. Op, mask and length are latched at E0. CMD_VALID during non-IDLE states is ignored and not queued.
- Transitions from IDLE on accept:
  - Ops 0-3 and 6-7 go to APPLY.
  - Ops 4-5 with CMD_LEN>0 go to COUNT, with a remaining-step counter loaded with CMD_LEN.
  - Ops 4-5 with CMD_LEN=0 go directly to FIN; Q is unchanged.
- APPLY lasts exactly 1 cycle, then goes to FIN. Drive per op:
  - HOLD: J=0, K=0.
  - SET: J=mask, K=0.
  - RESET: J=0, K=mask.
  - TOGGLE: J=K=mask.
  - Illegal: J=K=0, and ERR=1 during FIN.
  - Q updates at E1.
- COUNT drive, with bit 0 J=K=1:
  - COUNT_UP: J[i]=K[i]=AND of Q[i-1:0].
  - COUNT_DOWN: J[i]=K[i]=AND of QB[i-1:0].
  - Q increments or decrements modulo 2^WIDTH on each COUNT edge. It wraps silently: 1..1 goes to 0 when counting up, 0 goes to 1..1 when counting down.
  - The step counter decrements each edge. The state leaves COUNT for FIN on the edge that applies the last step, so Q changes at E1..En for LEN=n.
- FIN lasts 1 cycle with DONE=1, then returns to IDLE. The earliest next accept is the edge ending the first IDLE cycle.
- Latency from accept edge E0:
  - Ops 0-3: Q valid after E1; DONE high in the E1..E2 cycle; IDLE after E2.
  - Count of length n: DONE high in the En..En+1 cycle.
  - LEN=0: DONE high in the E0..E1 cycle.
- Q changes only in APPLY or COUNT, or on reset.

Test Plan:
- Reset held 2 cycles then released -> Q=0000, QB=1111, CMD_READY=1, BUSY=0, DONE=0, ERR=0.
- From Q=0000, SET mask=0101, then TOGGLE mask=1111, then RESET mask=0011 -> Q=0101, then 1010, then 1000. Each change lands at E1 after its accept; DONE pulses once per command; J_OUT/K_OUT match the op table during APPLY only.
- From Q=0000, COUNT_UP LEN=20 -> Q steps 1,2,…,15,0,…,4 on consecutive edges and ends at 0100 (wrap). DONE pulses once, in the cycle after the 20th step. BUSY stays high throughout.
- From Q=0000, COUNT_DOWN LEN=1 -> Q=1111 after one edge. Then COUNT_UP LEN=0 -> DONE in the cycle after accept, Q still 1111.
- CMD_OP=7, mask=1111, from Q=1010 -> Q stays 1010; DONE and ERR both high in the same single cycle.
- During COUNT_UP LEN=50: hold CMD_VALID=1 with SET mask=1111 -> not accepted, CMD_READY=0. Then assert RST_N=0 at step 10 -> Q=0000 on that edge, no DONE, IDLE with CMD_READY=1 on the first edge with RST_N=1.

Source files
------------

// File: rtl/jk_bank_ctrl.sv
// -----------------------------------------------------------------------------
// jk_bank_ctrl
//
// Command-driven sequencer that owns a bank of WIDTH JK flip-flops. One command
// is accepted at a time over a valid/ready handshake and turned into per-bit
// J/K drive: hold, set, reset, toggle, or a multi-cycle synchronous up/down
// count of programmable length.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   RST_N      synchronous active-low reset
//   CMD_VALID  command present
//   CMD_READY  block can accept a command (IDLE)
//   CMD_OP     0 HOLD, 1 SET, 2 RESET, 3 TOGGLE, 4 COUNT_UP, 5 COUNT_DOWN,
//              6-7 illegal
//   CMD_MASK   bit select for SET/RESET/TOGGLE
//   CMD_LEN    step count for COUNT_UP/COUNT_DOWN
//   J_OUT      J drive applied to the bank this cycle
//   K_OUT      K drive applied to the bank this cycle
//   Q          flop bank state
//   QB         ~Q
//   BUSY       command in progress
//   DONE       one-cycle completion pulse
//   ERR        one-cycle pulse with DONE when the op was illegal
// -----------------------------------------------------------------------------
module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_OP,
    input  logic [WIDTH-1:0] CMD_MASK,
    input  logic [LEN_W-1:0] CMD_LEN,
    output logic [WIDTH-1:0] J_OUT,
    output logic [WIDTH-1:0] K_OUT,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QB,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [2:0] OP_HOLD       = 3'd0;
    localparam logic [2:0] OP_SET        = 3'd1;
    localparam logic [2:0] OP_RESET      = 3'd2;
    localparam logic [2:0] OP_TOGGLE     = 3'd3;
    localparam logic [2:0] OP_COUNT_UP   = 3'd4;
    localparam logic [2:0] OP_COUNT_DOWN = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_COUNT,
        S_FIN
    } state_t;

    state_t           state, state_next;
    logic [2:0]       op_q, op_next;
    logic [WIDTH-1:0] mask_q, mask_next;
    logic [LEN_W-1:0] steps_q, steps_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] j_drive, k_drive;
    logic [WIDTH-1:0] up_drive, down_drive;

    function automatic logic is_count_op(input logic [2:0] op);
        return (op == OP_COUNT_UP) || (op == OP_COUNT_DOWN);
    endfunction

    // Synchronous counter carry chains: bit i toggles when every lower bit is
    // 1 (up) or 0 (down); bit 0 always toggles.
    always_comb begin
        logic carry_up;
        logic carry_down;
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        carry_up   = 1'b1;
        carry_down = 1'b1;
        up_drive   = '0;
        down_drive = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_drive[i]   = carry_up;
            down_drive[i] = carry_down;
            carry_up      = carry_up & q_reg[i];
            carry_down    = carry_down & ~q_reg[i];
        end
    end

    // Next-state, latched-field and J/K drive logic.
    always_comb begin
        state_next = state;
        op_next    = op_q;
        mask_next  = mask_q;
        steps_next = steps_q;
        j_drive    = '0;
        k_drive    = '0;

        case (state)
            S_IDLE: begin
                if (CMD_VALID) begin
                    op_next   = CMD_OP;
                    mask_next = CMD_MASK;
                    if (is_count_op(CMD_OP)) begin
                        steps_next = CMD_LEN;
                        // A zero-length count has nothing to apply.
                        state_next = (CMD_LEN == '0) ? S_FIN : S_COUNT;
                    end else begin
                        steps_next = '0;
                        state_next = S_APPLY;
                    end
                end
            end

            S_APPLY: begin
                case (op_q)
                    OP_SET:    j_drive = mask_q;
                    OP_RESET:  k_drive = mask_q;
                    OP_TOGGLE: begin
                        j_drive = mask_q;
                        k_drive = mask_q;
                    end
                    default: ;  // HOLD and illegal ops leave the bank alone
                endcase
                state_next = S_FIN;
            end

            S_COUNT: begin
                if (op_q == OP_COUNT_DOWN) begin
                    j_drive = down_drive;
                    k_drive = down_drive;
                end else begin
                    j_drive = up_drive;
                    k_drive = up_drive;
                end
                steps_next = steps_q - LEN_W'(1);
                // Leave on the edge that applies the final step.
                if (steps_q == LEN_W'(1)) begin
                    state_next = S_FIN;
                end
            end

            S_FIN: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // JK characteristic equation per bit: Q+ = J & ~Q | ~K & Q.
    assign q_next = (j_drive & ~q_reg) | (~k_drive & q_reg);

    // NOTE: reset is sampled on the clock edge only (synchronous), and it wins
    // over any command in flight, so an aborted command never reaches FIN.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            op_q    <= '0;
            mask_q  <= '0;
            steps_q <= '0;
            q_reg   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational logic.
            state   <= state_next;
            op_q    <= op_next;
            mask_q  <= mask_next;
            steps_q <= steps_next;
            q_reg   <= q_next;
        end
    end

    assign CMD_READY = (state == S_IDLE);
    assign BUSY      = (state != S_IDLE);
    assign DONE      = (state == S_FIN);
    assign ERR       = (state == S_FIN) && (op_q[2:1] == 2'b11);
    assign J_OUT     = j_drive;
    assign K_OUT     = k_drive;
    assign Q         = q_reg;
    assign QB        = ~q_reg;

    // Referenced so every op encoding is named in one place.
    logic unused_ops;
    assign unused_ops = ^{OP_HOLD};

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_ctrl
//
// Directed bench for jk_bank_ctrl (WIDTH=4, LEN_W=8). Each issued command
// pushes its expected final Q, ERR and DONE cycle into a scoreboard queue; a
// monitor pops and compares whenever DONE is seen. Per-cycle expectations
// (reset values, J/K drive, count steps, abort) are checked inline.
// -----------------------------------------------------------------------------
module tb_jk_bank_ctrl;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [LEN_W-1:0] cmd_len;
    logic [WIDTH-1:0] j_out, k_out, q, qb;
    logic             busy, done, err;

    jk_bank_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_OP    (cmd_op),
        .CMD_MASK  (cmd_mask),
        .CMD_LEN   (cmd_len),
        .J_OUT     (j_out),
        .K_OUT     (k_out),
        .Q         (q),
        .QB        (qb),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             err;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_q", q, e.q);
                    check("done_err", err, e.err);
                    check("done_cycle", cyc, e.cyc);
                end
            end else if (err === 1'b1) begin
                check("err_without_done", 32'd1, 32'd0);
            end
        end
    end

    // Issue one command; returns at #1 after the accept edge E0.
    task automatic do_cmd(input logic [2:0] op, input logic [WIDTH-1:0] mask,
                          input logic [LEN_W-1:0] len, input logic [WIDTH-1:0] eq,
                          input logic ee, input int lat, input bit expect_done);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (cmd_ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (expect_done) sb.push_back('{eq, ee, cyc + lat});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_mask  = '0;
        cmd_len   = '0;

        // Reset for two cycles, then release.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_q", q, 4'b0000);
        check("rst_qb", qb, 4'b1111);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_jk", {j_out, k_out}, 8'h00);
        @(posedge clk); #1;

        // SET 0101 -> 0101
        do_cmd(3'd1, 4'b0101, 8'd0, 4'b0101, 1'b0, 1, 1'b1);
        check("set_j", j_out, 4'b0101);
        check("set_k", k_out, 4'b0000);
        @(posedge clk); #1;
        check("set_q_e1", q, 4'b0101);
        check("set_jk_fin", {j_out, k_out}, 8'h00);
        wait_idle();

        // TOGGLE 1111 -> 1010
        do_cmd(3'd3, 4'b1111, 8'd0, 4'b1010, 1'b0, 1, 1'b1);
        check("tog_j", j_out, 4'b1111);
        check("tog_k", k_out, 4'b1111);
        @(posedge clk); #1;
        check("tog_q_e1", q, 4'b1010);
        wait_idle();

        // RESET 0011 -> 1000
        do_cmd(3'd2, 4'b0011, 8'd0, 4'b1000, 1'b0, 1, 1'b1);
        check("rstop_j", j_out, 4'b0000);
        check("rstop_k", k_out, 4'b0011);
        @(posedge clk); #1;
        check("rstop_q_e1", q, 4'b1000);
        wait_idle();

        // COUNT_UP 20 from 0000: wraps once, ends at 0100.
        do_cmd(3'd2, 4'b1111, 8'd0, 4'b0000, 1'b0, 1, 1'b1);
        wait_idle();
        do_cmd(3'd4, 4'b0000, 8'd20, 4'b0100, 1'b0, 20, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            check($sformatf("up_q_%0d", k), q, 32'(k % 16));
            check($sformatf("up_busy_%0d", k), busy, 1'b1);
        end
        wait_idle();

        // COUNT_DOWN 1 from 0000 -> 1111, then zero-length COUNT_UP.
        do_cmd(3'd2, 4'b1111, 8'd0, 4'b0000, 1'b0, 1, 1'b1);
        wait_idle();
        do_cmd(3'd5, 4'b0000, 8'd1, 4'b1111, 1'b0, 1, 1'b1);
        wait_idle();
        do_cmd(3'd4, 4'b0000, 8'd0, 4'b1111, 1'b0, 0, 1'b1);
        check("len0_jk", {j_out, k_out}, 8'h00);
        wait_idle();
        check("len0_q", q, 4'b1111);

        // Illegal op 7 from 1010: Q unchanged, ERR with DONE.
        do_cmd(3'd2, 4'b1111, 8'd0, 4'b0000, 1'b0, 1, 1'b1);
        wait_idle();
        do_cmd(3'd1, 4'b1010, 8'd0, 4'b1010, 1'b0, 1, 1'b1);
        wait_idle();
        do_cmd(3'd7, 4'b1111, 8'd0, 4'b1010, 1'b1, 1, 1'b1);
        check("ill_jk", {j_out, k_out}, 8'h00);
        wait_idle();

        // COUNT_UP 50 with a competing SET held, aborted by reset at step 10.
        do_cmd(3'd2, 4'b1111, 8'd0, 4'b0000, 1'b0, 1, 1'b1);
        wait_idle();
        do_cmd(3'd4, 4'b0000, 8'd50, 4'b0000, 1'b0, 0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_mask  = 4'b1111;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort_ready_%0d", k), cmd_ready, 1'b0);
            check($sformatf("abort_q_%0d", k), q, 32'(k));
        end
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_q_rst", q, 4'b0000);
        check("abort_qb_rst", qb, 4'b1111);
        check("abort_busy_rst", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_after", cmd_ready, 1'b1);
        check("abort_q_after", q, 4'b0000);
        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
